// File: rtl/i2c_reg_master_if.sv
// i2c_reg_master_if: command/response handshake plus I2C pad signals.
//   cmd_*   : one write-byte or read-byte request (valid/ready)
//   rsp_*   : one-cycle completion pulse with read byte and NACK flag
//   busy    : transaction in flight
//   scl_*/sda_* : open-drain pads; *_t mirrors *_o (1 = released)
// Modports: master = the I2C master block's view, slave = the
// controlling logic / pad side that feeds it.
interface i2c_reg_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_addr;
  logic       cmd_read;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       busy;
  logic       scl_i, scl_o, scl_t;
  logic       sda_i, sda_o, sda_t;

  modport master (
    input  cmd_valid, cmd_addr, cmd_read, cmd_data, scl_i, sda_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack, busy,
           scl_o, scl_t, sda_o, sda_t
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_read, cmd_data, scl_i, sda_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack, busy,
           scl_o, scl_t, sda_o, sda_t
  );
endinterface

// File: rtl/i2c_reg_master.sv
// i2c_reg_master: single-transaction I2C master (1-byte write or 1-byte read).
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : i2c_reg_master_if.master (command, response, SCL/SDA pads)
// Parameter PRESCALE: clk cycles per quarter SCL period (1..65535).
// Each bit is four phases P0..P3: SCL low in P0/P1, released in P2/P3.
// SDA changes only at P0 entry and is sampled on the last clk of P2.
module i2c_reg_master #(
  parameter int PRESCALE = 4
) (
  input logic             clk,
  input logic             rst_n,
  i2c_reg_master_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE, S_WRITE_ACK,
    S_READ, S_READ_NACK, S_STOP, S_DONE
  } state_t;

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic [1:0]  phase;
  logic [2:0]  bit_cnt;
  logic [6:0]  addr_q;
  logic        read_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rx_sh;
  logic        nack_q;
  logic [7:0]  rsp_data_q;
  logic        rsp_nack_q;
  logic        scl, sda;
  logic [7:0]  addr_byte;

  logic accept, active, stretch, tick, sample, bit_end, last_bit, multi_bit;

  assign addr_byte = {addr_q, read_q};
  assign accept    = (state == S_IDLE) && bus.cmd_valid;
  assign active    = (state != S_IDLE) && (state != S_DONE);
  // A slave holding SCL low while we release it freezes the phase timer.
  assign stretch   = scl & ~bus.scl_i;
  assign tick      = active && !stretch && (cnt == PS_LAST);
  assign sample    = tick && (phase == 2'd2);
  assign bit_end   = tick && (phase == 2'd3);
  assign last_bit  = (bit_cnt == 3'd0);
  assign multi_bit = (state == S_ADDR) || (state == S_WRITE) || (state == S_READ);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      phase      <= '0;
      bit_cnt    <= 3'd7;
      addr_q     <= '0;
      read_q     <= 1'b0;
      wdata_q    <= '0;
      rx_sh      <= '0;
      nack_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_nack_q <= 1'b0;
    end else begin
      state <= state_nx;

      if (!active) begin
        cnt   <= '0;
        phase <= '0;
      end else if (!stretch) begin
        if (cnt == PS_LAST) begin
          cnt   <= '0;
          phase <= phase + 2'd1;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end

      if (accept) begin
        addr_q     <= bus.cmd_addr;
        read_q     <= bus.cmd_read;
        wdata_q    <= bus.cmd_data;
        rx_sh      <= '0;
        nack_q     <= 1'b0;
        rsp_data_q <= '0;
        rsp_nack_q <= 1'b0;
        bit_cnt    <= 3'd7;
      end

      // 3-bit down counter wraps 0 -> 7, so it is already reloaded for
      // the next byte state; single-bit states never touch it.
      if (bit_end && multi_bit)
        bit_cnt <= bit_cnt - 3'd1;

      if (sample) begin
        case (state)
          S_ADDR_ACK, S_WRITE_ACK: nack_q <= bus.sda_i;
          S_READ:                  rx_sh  <= {rx_sh[6:0], bus.sda_i};
          default: ;
        endcase
      end

      // Results become visible together with the DONE pulse.
      if (state == S_STOP && bit_end) begin
        rsp_data_q <= rx_sh;
        rsp_nack_q <= nack_q;
      end
    end
  end

  always_comb begin
    state_nx = state;
    scl      = 1'b1;
    sda      = 1'b1;
    case (state)
      S_IDLE:      if (bus.cmd_valid) state_nx = S_START;
      S_START: begin
        sda = ~phase[1];
        if (bit_end) state_nx = S_ADDR;
      end
      S_ADDR: begin
        scl = phase[1];
        sda = addr_byte[bit_cnt];
        if (bit_end && last_bit) state_nx = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        scl = phase[1];
        if (bit_end) state_nx = nack_q ? S_STOP : (read_q ? S_READ : S_WRITE);
      end
      S_WRITE: begin
        scl = phase[1];
        sda = wdata_q[bit_cnt];
        if (bit_end && last_bit) state_nx = S_WRITE_ACK;
      end
      S_WRITE_ACK: begin
        scl = phase[1];
        if (bit_end) state_nx = S_STOP;
      end
      S_READ: begin
        scl = phase[1];
        if (bit_end && last_bit) state_nx = S_READ_NACK;
      end
      S_READ_NACK: begin
        scl = phase[1];
        if (bit_end) state_nx = S_STOP;
      end
      S_STOP: begin
        scl = (phase != 2'd0);
        sda = (phase == 2'd3);
        if (bit_end) state_nx = S_DONE;
      end
      S_DONE:      state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  assign bus.scl_o     = scl;
  assign bus.scl_t     = scl;
  assign bus.sda_o     = sda;
  assign bus.sda_t     = sda;
  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.rsp_valid = (state == S_DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_nack  = rsp_nack_q;

endmodule

// File: tb/tb_i2c_reg_master.sv
// tb_i2c_reg_master: directed bench for i2c_reg_master (PRESCALE=4) with a
// behavioural single-register slave at 0x70 on an open-drain bus.
module tb_i2c_reg_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_reg_master_if bus();

  i2c_reg_master #(.PRESCALE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- slave model ----------------
  localparam logic [6:0] SL_ADDR = 7'h70;
  logic       scl_hold    = 1'b0;
  logic       sl_data_ack = 1'b1;
  logic       sl_drv      = 1'b1;
  logic       scl_p       = 1'b1;
  logic       sda_p       = 1'b1;
  logic [3:0] sl_cnt      = 4'd0;
  int         sl_byte     = 0;
  int         sl_nb       = 0;
  int         sl_stops    = 0;
  logic [7:0] sl_sh       = 8'h00;
  logic       sl_sel      = 1'b0;
  logic       sl_rd       = 1'b0;
  logic       sl_mack     = 1'b0;
  logic [7:0] sl_reg      = 8'h00;
  logic [7:0] sl_log [0:3];

  assign bus.scl_i = bus.scl_o & ~scl_hold;
  assign bus.sda_i = bus.sda_o & sl_drv;

  always @(posedge clk) begin
    scl_p <= bus.scl_i;
    sda_p <= bus.sda_i;
    if (scl_p && bus.scl_i && sda_p && !bus.sda_i) begin
      sl_cnt <= 4'd0; sl_byte <= 0; sl_nb <= 0; sl_sel <= 1'b0; sl_drv <= 1'b1;
    end else if (scl_p && bus.scl_i && !sda_p && bus.sda_i) begin
      sl_sel <= 1'b0; sl_drv <= 1'b1; sl_stops <= sl_stops + 1;
    end else if (!scl_p && bus.scl_i) begin
      if (sl_cnt < 4'd8) sl_sh <= {sl_sh[6:0], bus.sda_i};
      else if (sl_sel && sl_rd && sl_byte > 0) begin
        sl_mack <= bus.sda_i;
        if (bus.sda_i) sl_sel <= 1'b0;
      end
      if (sl_cnt == 4'd7 && sl_nb < 4) begin
        sl_log[sl_nb] <= {sl_sh[6:0], bus.sda_i};
        sl_nb <= sl_nb + 1;
      end
      sl_cnt <= sl_cnt + 4'd1;
    end else if (scl_p && !bus.scl_i) begin
      if (sl_cnt == 4'd8) begin
        sl_drv <= 1'b1;
        if (sl_byte == 0) begin
          if (sl_sh[7:1] == SL_ADDR) begin
            sl_sel <= 1'b1; sl_rd <= sl_sh[0]; sl_drv <= 1'b0;
          end
        end else if (sl_sel && !sl_rd && sl_data_ack) begin
          sl_reg <= sl_sh; sl_drv <= 1'b0;
        end
      end else if (sl_cnt == 4'd9) begin
        sl_cnt  <= 4'd0;
        sl_byte <= sl_byte + 1;
        sl_drv  <= (sl_sel && sl_rd) ? sl_reg[7] : 1'b1;
      end else if (sl_cnt >= 4'd1 && sl_cnt <= 4'd7 && sl_sel && sl_rd && sl_byte > 0) begin
        sl_drv <= sl_reg[3'(4'd7 - sl_cnt)];
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  int         lat;
  logic [7:0] rdat, rdat_a;
  logic       rnack, bz, r1, ra, rva;
  int         stops0;
  logic       rv_seen;

  // Call right after a negedge while idle. lat = cycles from the accept
  // cycle to the rsp_valid cycle, -1 on timeout.
  task automatic run_cmd(input logic [6:0] a, input logic r, input logic [7:0] d,
                         input logic hold_v,
                         output int l, output logic [7:0] rd, output logic rn,
                         output logic busy_rsp, output logic rdy1,
                         output logic rdy_after, output logic rv_after,
                         output logic [7:0] rd_after);
    bus.cmd_addr  = a;
    bus.cmd_read  = r;
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    l = -1; rd = 8'hxx; rn = 1'bx; busy_rsp = 1'bx; rdy1 = 1'bx;
    @(posedge clk);
    #1;
    if (!hold_v) bus.cmd_valid = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (n == 1) rdy1 = bus.cmd_ready;
      if (bus.rsp_valid) begin
        l = n; rd = bus.rsp_data; rn = bus.rsp_nack; busy_rsp = bus.busy;
        break;
      end
    end
    @(negedge clk);
    rdy_after = bus.cmd_ready;
    rv_after  = bus.rsp_valid;
    rd_after  = bus.rsp_data;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_read  = 1'b0;
    bus.cmd_data  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_rv",    32'(bus.rsp_valid), 0);
    chk("rst_rdata", 32'(bus.rsp_data), 0);
    chk("rst_nack",  32'(bus.rsp_nack), 0);
    chk("rst_scl",   32'({bus.scl_o, bus.scl_t}), 32'b11);
    chk("rst_sda",   32'({bus.sda_o, bus.sda_t}), 32'b11);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 0xA5 to 0x70
    run_cmd(7'h70, 1'b0, 8'hA5, 1'b0, lat, rdat, rnack, bz, r1, ra, rva, rdat_a);
    chk("wr_lat",     32'(lat), 321);
    chk("wr_nack",    32'(rnack), 0);
    chk("wr_rdata",   32'(rdat), 0);
    chk("wr_busy",    32'(bz), 1);
    chk("wr_rdy1",    32'(r1), 0);
    chk("wr_rdy_aft", 32'(ra), 1);
    chk("wr_rv_aft",  32'(rva), 0);
    chk("wr_byte0",   32'(sl_log[0]), 32'hE0);
    chk("wr_byte1",   32'(sl_log[1]), 32'hA5);
    chk("wr_slreg",   32'(sl_reg), 32'hA5);

    // Read back
    run_cmd(7'h70, 1'b1, 8'h00, 1'b0, lat, rdat, rnack, bz, r1, ra, rva, rdat_a);
    chk("rd_lat",   32'(lat), 321);
    chk("rd_data",  32'(rdat), 32'hA5);
    chk("rd_nack",  32'(rnack), 0);
    chk("rd_hold",  32'(rdat_a), 32'hA5);
    chk("rd_byte0", 32'(sl_log[0]), 32'hE1);
    chk("rd_mnack", 32'(sl_mack), 1);

    // Wrong address, cmd_valid held high throughout (must be ignored while busy)
    stops0 = sl_stops;
    run_cmd(7'h21, 1'b0, 8'h3C, 1'b1, lat, rdat, rnack, bz, r1, ra, rva, rdat_a);
    chk("na_lat",    32'(lat), 177);
    chk("na_nack",   32'(rnack), 1);
    chk("na_rdata",  32'(rdat), 0);
    chk("na_nbytes", 32'(sl_nb), 1);
    chk("na_byte0",  32'(sl_log[0]), 32'h42);
    chk("na_stop",   32'(sl_stops - stops0), 1);
    chk("na_rdy_aft", 32'(ra), 1);

    // Data NACK
    sl_data_ack = 1'b0;
    stops0 = sl_stops;
    run_cmd(7'h70, 1'b0, 8'h55, 1'b0, lat, rdat, rnack, bz, r1, ra, rva, rdat_a);
    chk("dn_lat",   32'(lat), 321);
    chk("dn_nack",  32'(rnack), 1);
    chk("dn_byte1", 32'(sl_log[1]), 32'h55);
    chk("dn_slreg", 32'(sl_reg), 32'hA5);
    chk("dn_stop",  32'(sl_stops - stops0), 1);
    sl_data_ack = 1'b1;

    // Clock stretch: 50 frozen clocks at the first SCL-high of the data byte
    fork
      run_cmd(7'h70, 1'b0, 8'h3C, 1'b0, lat, rdat, rnack, bz, r1, ra, rva, rdat_a);
      begin
        int n;
        n = 0;
        for (int k = 0; k < 3000 && !(bus.busy && sl_byte == 0); k++) @(negedge clk);
        for (int k = 0; k < 3000 && !(sl_byte == 1 && sl_cnt == 4'd0 && !bus.scl_o); k++)
          @(negedge clk);
        scl_hold = 1'b1;
        for (int k = 0; k < 3000; k++) begin
          @(negedge clk);
          if (bus.scl_o) begin
            if (n == 50) break;
            n++;
          end
        end
        scl_hold = 1'b0;
      end
    join
    chk("st_lat",   32'(lat), 371);
    chk("st_nack",  32'(rnack), 0);
    chk("st_byte0", 32'(sl_log[0]), 32'hE0);
    chk("st_byte1", 32'(sl_log[1]), 32'h3C);
    chk("st_slreg", 32'(sl_reg), 32'h3C);

    // Reset during WRITE bit 3
    bus.cmd_addr = 7'h70; bus.cmd_read = 1'b0; bus.cmd_data = 8'h96;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int k = 0; k < 3000 && !(bus.busy && sl_byte == 0); k++) @(negedge clk);
    for (int k = 0; k < 3000 && !(sl_byte == 1 && sl_cnt == 4'd4 && !bus.scl_o); k++)
      @(negedge clk);
    chk("mr_reached", 32'(bus.busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_scl",   32'(bus.scl_o), 1);
    chk("mr_sda",   32'(bus.sda_o), 1);
    chk("mr_ready", 32'(bus.cmd_ready), 1);
    chk("mr_busy",  32'(bus.busy), 0);
    chk("mr_rv",    32'(bus.rsp_valid), 0);
    rst_n = 1'b1;
    rv_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid) rv_seen = 1'b1;
    end
    chk("mr_no_rsp", 32'(rv_seen), 0);
    run_cmd(7'h70, 1'b0, 8'h5A, 1'b0, lat, rdat, rnack, bz, r1, ra, rva, rdat_a);
    chk("mr_lat",   32'(lat), 321);
    chk("mr_nack",  32'(rnack), 0);
    chk("mr_slreg", 32'(sl_reg), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
